// File: rtl/c16_mem_pkg.sv
// rtl/c16_mem_pkg.sv - shared constants for the c16 memory port arbiter
//
// Purpose: requester ids, default read latency and bus widths used by the
// port-B arbiter and its response pipeline.
// Ports: none (package).

package c16_mem_pkg;

  // Requester ids; also the encoding carried in the response pipeline.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  // ram2 port B reads are synchronous: data one cycle after the address.
  localparam int DEF_READ_LATENCY = 1;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

endpackage

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - {valid,id} shift register tracking reads in flight
//
// Purpose: one entry enters per cycle; the entry leaving the last stage marks
// the cycle in which the memory read data is valid and who it belongs to.
// Ports:
//   i_clk        clock, rising edge
//   i_clr        synchronous clear of every stage (drops pending responses)
//   i_valid      a read was granted this cycle
//   i_id         requester id of that read
//   o_resp_valid read data is on mem_q this cycle
//   o_resp_id    requester that owns the data
//   o_empty      no read anywhere in the pipeline

module mem_resp_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_valid,
  input  logic i_id,
  output logic o_resp_valid,
  output logic o_resp_id,
  output logic o_empty
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_id;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          r_valid <= '0;
          r_id    <= '0;
        end else begin
          r_valid <= i_valid;
          r_id    <= i_id;
        end
      end
    end else begin : g_multi
      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          r_valid <= '0;
          r_id    <= '0;
        end else begin
          r_valid <= {r_valid[DEPTH-2:0], i_valid};
          r_id    <= {r_id[DEPTH-2:0], i_id};
        end
      end
    end
  endgenerate

  assign o_resp_valid = r_valid[DEPTH-1];
  assign o_resp_id    = r_id[DEPTH-1];
  // The stage currently presenting a response still counts as in flight.
  assign o_empty      = ~|r_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of ram2 port B between CPU and debug loader
//
// Purpose: per-cycle combinational grant between the execute stage and the
// debug loader, drives ram2 port B from the winner, and steers the read data
// back READ_LATENCY cycles later. drain freezes new grants; idle reports that
// nothing is granted and no read is in flight.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata CPU accept, read response
//   dbg_req/we/addr/wdata          debug loader request, held until dbg_gnt
//   dbg_gnt, dbg_rvalid, dbg_rdata debug accept, read response
//   drain, idle                    stop new grants / quiescent status
//   mem_addr/data/wren, mem_q      ram2 address_b/data_b/wren_b/q_b
// READ_LATENCY legal range is 1..3.

module mem_port_arbiter
  import c16_mem_pkg::*;
#(
  parameter int READ_LATENCY = c16_mem_pkg::DEF_READ_LATENCY,
  parameter int ADDR_W       = c16_mem_pkg::ADDR_W,
  parameter int DATA_W       = c16_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              drain,
  output logic              idle,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  req_id_e r_last_winner;

  logic w_cpu_gnt;
  logic w_dbg_gnt;
  logic w_any_gnt;
  logic w_issue_rd;
  logic w_resp_valid;
  logic w_resp_id;
  logic w_pipe_empty;

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!rst && !drain) begin
      if (cpu_req && dbg_req) begin
        if (r_last_winner == REQ_DBG) begin
          w_cpu_gnt = 1'b1;
        end else begin
          w_dbg_gnt = 1'b1;
        end
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        w_dbg_gnt = 1'b1;
      end
    end
  end

  assign w_any_gnt = w_cpu_gnt | w_dbg_gnt;

  // Port B is driven only in a grant cycle, so wren can never fire ungranted.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (w_cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
      mem_wren = cpu_we;
    end else if (w_dbg_gnt) begin
      mem_addr = dbg_addr;
      mem_data = dbg_wdata;
      mem_wren = dbg_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_winner <= REQ_DBG;
    end else if (w_cpu_gnt) begin
      r_last_winner <= REQ_CPU;
    end else if (w_dbg_gnt) begin
      r_last_winner <= REQ_DBG;
    end
  end

  assign w_issue_rd = (w_cpu_gnt && !cpu_we) || (w_dbg_gnt && !dbg_we);

  mem_resp_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_resp_pipe (
    .i_clk       (clk),
    .i_clr       (rst),
    .i_valid     (w_issue_rd),
    .i_id        (w_dbg_gnt),
    .o_resp_valid(w_resp_valid),
    .o_resp_id   (w_resp_id),
    .o_empty     (w_pipe_empty)
  );

  // Masking with rst keeps a response from leaking out during the reset cycle.
  assign cpu_rvalid = w_resp_valid && !rst && (w_resp_id == REQ_CPU);
  assign dbg_rvalid = w_resp_valid && !rst && (w_resp_id == REQ_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_q : '0;

  assign cpu_gnt = w_cpu_gnt;
  assign dbg_gnt = w_dbg_gnt;
  assign idle    = !w_any_gnt && w_pipe_empty;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at read latencies 1, 2 and 3

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        drain;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        cpu_gnt    [1:3];
  logic        cpu_rvalid [1:3];
  logic        dbg_gnt    [1:3];
  logic        dbg_rvalid [1:3];
  logic        idle       [1:3];
  logic        mem_wren   [1:3];
  logic [15:0] cpu_rdata  [1:3];
  logic [15:0] dbg_rdata  [1:3];
  logic [15:0] mem_addr   [1:3];
  logic [15:0] mem_data   [1:3];
  logic [15:0] mem_q      [1:3];

  int checks = 0;
  int errors = 0;

  // Instance k runs with READ_LATENCY = k against a write-first RAM whose
  // read data appears k cycles after the address.
  for (genvar k = 1; k <= 3; k++) begin : g_dut
    logic [15:0] ram    [0:255];
    logic [15:0] q_pipe [0:k-1];

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      for (int j = 0; j < k; j++) q_pipe[j] = 16'h0000;
      ram[8'h10] = 16'hBEEF;
      ram[8'h20] = 16'h1111;
      ram[8'h30] = 16'h2222;
      ram[8'h50] = 16'hA5A5;
      ram[8'h60] = 16'h5A5A;
      ram[8'h70] = 16'hC3C3;
    end

    always @(posedge clk) begin
      if (mem_wren[k]) ram[mem_addr[k][7:0]] <= mem_data[k];
      q_pipe[0] <= mem_wren[k] ? mem_data[k] : ram[mem_addr[k][7:0]];
      for (int j = 1; j < k; j++) q_pipe[j] <= q_pipe[j-1];
    end

    assign mem_q[k] = q_pipe[k-1];

    mem_port_arbiter #(
      .READ_LATENCY(k),
      .ADDR_W      (16),
      .DATA_W      (16)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt[k]),
      .cpu_rvalid(cpu_rvalid[k]),
      .cpu_rdata (cpu_rdata[k]),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt[k]),
      .dbg_rvalid(dbg_rvalid[k]),
      .dbg_rdata (dbg_rdata[k]),
      .drain     (drain),
      .idle      (idle[k]),
      .mem_addr  (mem_addr[k]),
      .mem_data  (mem_data[k]),
      .mem_wren  (mem_wren[k]),
      .mem_q     (mem_q[k])
    );
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drain = 1'b0;
    quiet();

    // Reset: a request during rst is never granted.
    step(); drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("rst_no_cpu_gnt", cpu_gnt[1], 1'b0);
    chk1("rst_no_wren", mem_wren[1], 1'b0);
    step(); rst = 1'b0; quiet(); #1;
    for (int i = 1; i <= 3; i++) begin
      chk1("post_rst_idle", idle[i], 1'b1);
      chk1("post_rst_cpu_rvalid", cpu_rvalid[i], 1'b0);
    end

    // CPU read alone of 0x0010 (holds 0xBEEF).
    step(); drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("rd_cpu_gnt", cpu_gnt[1], 1'b1);
    chk1("rd_dbg_gnt", dbg_gnt[1], 1'b0);
    chk16("rd_mem_addr", mem_addr[1], 16'h0010);
    chk1("rd_mem_wren", mem_wren[1], 1'b0);
    step(); quiet(); #1;
    chk1("rd_l1_rvalid", cpu_rvalid[1], 1'b1);
    chk16("rd_l1_rdata", cpu_rdata[1], 16'hBEEF);
    chk1("rd_l1_dbg_rvalid", dbg_rvalid[1], 1'b0);
    chk1("rd_l2_early", cpu_rvalid[2], 1'b0);
    chk16("rd_idle_mem_addr", mem_addr[1], 16'h0000);
    step(); #1;
    chk1("rd_l1_one_cycle", cpu_rvalid[1], 1'b0);
    chk16("rd_l1_rdata_zero", cpu_rdata[1], 16'h0000);
    chk1("rd_l2_rvalid", cpu_rvalid[2], 1'b1);
    chk16("rd_l2_rdata", cpu_rdata[2], 16'hBEEF);
    step(); #1;
    chk1("rd_l3_rvalid", cpu_rvalid[3], 1'b1);
    chk16("rd_l3_rdata", cpu_rdata[3], 16'hBEEF);
    step(); #1;
    chk1("rd_l3_idle", idle[3], 1'b1);

    // Contention after a fresh reset: CPU, DBG, CPU, DBG.
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0); #1;
    chk1("ct0_cpu_gnt", cpu_gnt[1], 1'b1);
    chk1("ct0_dbg_gnt", dbg_gnt[1], 1'b0);
    chk16("ct0_mem_addr", mem_addr[1], 16'h0020);
    step(); #1;
    chk1("ct1_dbg_gnt", dbg_gnt[1], 1'b1);
    chk1("ct1_cpu_gnt", cpu_gnt[1], 1'b0);
    chk16("ct1_mem_addr", mem_addr[1], 16'h0030);
    chk1("ct1_cpu_rvalid", cpu_rvalid[1], 1'b1);
    chk16("ct1_cpu_rdata", cpu_rdata[1], 16'h1111);
    step(); #1;
    chk1("ct2_cpu_gnt", cpu_gnt[1], 1'b1);
    chk1("ct2_dbg_rvalid", dbg_rvalid[1], 1'b1);
    chk16("ct2_dbg_rdata", dbg_rdata[1], 16'h2222);
    chk1("ct2_cpu_rvalid", cpu_rvalid[1], 1'b0);
    step(); #1;
    chk1("ct3_dbg_gnt", dbg_gnt[1], 1'b1);
    chk1("ct3_cpu_rvalid", cpu_rvalid[1], 1'b1);
    chk16("ct3_cpu_rdata", cpu_rdata[1], 16'h1111);
    step(); quiet(); #1;
    chk1("ct4_dbg_rvalid", dbg_rvalid[1], 1'b1);
    chk16("ct4_dbg_rdata", dbg_rdata[1], 16'h2222);
    chk1("ct4_no_gnt", cpu_gnt[1] | dbg_gnt[1], 1'b0);

    // Debug write 0x1234 to 0x0040, then CPU read of 0x0040.
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234); #1;
    chk1("wr_dbg_gnt", dbg_gnt[1], 1'b1);
    chk1("wr_mem_wren", mem_wren[1], 1'b1);
    chk16("wr_mem_addr", mem_addr[1], 16'h0040);
    chk16("wr_mem_data", mem_data[1], 16'h1234);
    step(); drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("wr_rd_cpu_gnt", cpu_gnt[1], 1'b1);
    chk1("wr_rd_wren", mem_wren[1], 1'b0);
    chk1("wr_no_rvalid", dbg_rvalid[1], 1'b0);
    step(); quiet(); #1;
    chk1("wr_rd_rvalid", cpu_rvalid[1], 1'b1);
    chk16("wr_rd_rdata", cpu_rdata[1], 16'h1234);
    chk1("wr_rd_wren_idle", mem_wren[1], 1'b0);
    step(); step(); #1;

    // Drain with a read in flight and both requesters waiting.
    step(); drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("dr_pre_cpu_gnt", cpu_gnt[1], 1'b1);
    step(); drain = 1'b1;
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0); #1;
    chk1("dr0_cpu_gnt", cpu_gnt[1], 1'b0);
    chk1("dr0_dbg_gnt", dbg_gnt[1], 1'b0);
    chk16("dr0_mem_addr", mem_addr[1], 16'h0000);
    chk1("dr0_cpu_rvalid", cpu_rvalid[1], 1'b1);
    chk16("dr0_cpu_rdata", cpu_rdata[1], 16'hA5A5);
    chk1("dr0_idle", idle[1], 1'b0);
    step(); #1;
    chk1("dr1_no_gnt", cpu_gnt[1] | dbg_gnt[1], 1'b0);
    chk1("dr1_idle", idle[1], 1'b1);
    chk1("dr1_cpu_rvalid", cpu_rvalid[1], 1'b0);
    step(); drain = 1'b0; #1;
    chk1("dr_rel_dbg_gnt", dbg_gnt[1], 1'b1);
    chk1("dr_rel_cpu_gnt", cpu_gnt[1], 1'b0);
    step(); quiet(); #1;
    chk1("dr_rel_dbg_rvalid", dbg_rvalid[1], 1'b1);
    chk16("dr_rel_dbg_rdata", dbg_rdata[1], 16'h2222);
    step(); step(); step(); #1;
    chk1("dr_l3_idle", idle[3], 1'b1);

    // Reset while a read is in flight (latency 2 and 3 instances).
    step(); drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("rm_cpu_gnt", cpu_gnt[2], 1'b1);
    step(); rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0); #1;
    chk1("rm_rst_cpu_gnt", cpu_gnt[2], 1'b0);
    chk1("rm_rst_dbg_gnt", dbg_gnt[2], 1'b0);
    step(); rst = 1'b0; quiet(); #1;
    chk1("rm_l2_no_rvalid", cpu_rvalid[2], 1'b0);
    chk16("rm_l2_rdata", cpu_rdata[2], 16'h0000);
    chk1("rm_l2_idle", idle[2], 1'b1);
    step(); drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0); #1;
    chk1("rm_tie_cpu_gnt", cpu_gnt[2], 1'b1);
    chk1("rm_tie_dbg_gnt", dbg_gnt[2], 1'b0);
    chk1("rm_l3_no_rvalid", cpu_rvalid[3], 1'b0);
    step(); quiet(); #1;
    step(); step(); step(); step(); #1;
    chk1("rm_l3_idle", idle[3], 1'b1);

    // Latency 3: CPU, DBG, CPU reads back to back.
    step(); drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("l3_t0_cpu_gnt", cpu_gnt[3], 1'b1);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0060, 16'h0); #1;
    chk1("l3_t1_dbg_gnt", dbg_gnt[3], 1'b1);
    step(); drive(1'b1, 1'b0, 16'h0070, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
    chk1("l3_t2_cpu_gnt", cpu_gnt[3], 1'b1);
    chk1("l3_t2_no_rvalid", cpu_rvalid[3] | dbg_rvalid[3], 1'b0);
    step(); quiet(); #1;
    chk1("l3_t3_cpu_rvalid", cpu_rvalid[3], 1'b1);
    chk16("l3_t3_cpu_rdata", cpu_rdata[3], 16'hA5A5);
    chk1("l3_t3_dbg_rvalid", dbg_rvalid[3], 1'b0);
    step(); #1;
    chk1("l3_t4_dbg_rvalid", dbg_rvalid[3], 1'b1);
    chk16("l3_t4_dbg_rdata", dbg_rdata[3], 16'h5A5A);
    chk1("l3_t4_cpu_rvalid", cpu_rvalid[3], 1'b0);
    step(); #1;
    chk1("l3_t5_cpu_rvalid", cpu_rvalid[3], 1'b1);
    chk16("l3_t5_cpu_rdata", cpu_rdata[3], 16'hC3C3);
    step(); #1;
    chk1("l3_t6_cpu_rvalid", cpu_rvalid[3], 1'b0);
    chk1("l3_t6_idle", idle[3], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
